// File: rtl/wb_prog_ctrl.sv
// Wishbone bitstream loader: buffers 32-bit words in a FIFO and shifts them MSB-first onto the fabric scan chain.
// Define PROG_READBACK_EN to add the RDATA readback shifter at offset 0x10.
module wb_prog_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        prog_rst,
  output logic        prog_done,
  output logic        prog_we,
  output logic        prog_din,
  input  logic        prog_dout,
  input  logic        prog_we_o,
  output logic        irq
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam logic [4:0]  DepthW = 5'(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} serState_e;

  serState_e   state_q, state_d;
  logic [31:0] shiftReg_q, shiftReg_d;
  logic [4:0]  bitCnt_q, bitCnt_d;
  logic [31:0] wordCount_q, wordCount_d;

  logic [31:0]   fifoMem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [4:0]    fifoCount_q;

  logic ack_q, progRst_q, progDone_q, irqEn_q, err_q, irq_q;
  logic req, ackD, stall, wrStrobe, ctrlWr, dataWr, flush, dropWord, push, pop;
  logic full, empty, busy;
  logic [7:0]  offset;
  logic [31:0] rdData, rdataVal;
  logic [4:0]  rbCnt;

  assign offset   = wbs_adr_i[7:0];
  assign req      = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign wrStrobe = ack_q & req & wbs_we_i;
  assign ctrlWr   = wrStrobe & (offset == 8'h00) & wbs_sel_i[0];
  assign dataWr   = wrStrobe & (offset == 8'h08);
  assign flush    = ctrlWr & wbs_dat_i[0];
  assign dropWord = progRst_q | progDone_q;
  assign push     = dataWr & ~dropWord;

  assign full  = (fifoCount_q == DepthW);
  assign empty = (fifoCount_q == 5'd0);
  assign busy  = (state_q == SHIFT) | ~empty;

  // A full FIFO holds off the ack; releasing it in a pop cycle lets the push land one cycle later.
  assign stall = req & wbs_we_i & (offset == 8'h08) & ~dropWord & full & ~pop;
  assign ackD  = req & ~ack_q & ~stall;

  always_comb begin
    state_d     = state_q;
    shiftReg_d  = shiftReg_q;
    bitCnt_d    = bitCnt_q;
    wordCount_d = wordCount_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !progRst_q) begin
          pop        = 1'b1;
          shiftReg_d = fifoMem_q[rdPtr_q];
          bitCnt_d   = 5'd0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        shiftReg_d = {shiftReg_q[30:0], 1'b0};
        bitCnt_d   = bitCnt_q + 5'd1;
        if (bitCnt_q == 5'd31) begin
          wordCount_d = wordCount_q + 32'd1;
          if (!empty) begin
            pop        = 1'b1;
            shiftReg_d = fifoMem_q[rdPtr_q];
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d     = IDLE;
      shiftReg_d  = 32'd0;
      bitCnt_d    = 5'd0;
      wordCount_d = 32'd0;
      pop         = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      shiftReg_q  <= 32'd0;
      bitCnt_q    <= 5'd0;
      wordCount_q <= 32'd0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fifoCount_q <= 5'd0;
      ack_q       <= 1'b0;
      progRst_q   <= 1'b1;
      progDone_q  <= 1'b0;
      irqEn_q     <= 1'b0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shiftReg_q  <= shiftReg_d;
      bitCnt_q    <= bitCnt_d;
      wordCount_q <= wordCount_d;
      ack_q       <= ackD;
      irq_q       <= irqEn_q & ~progRst_q & ~busy;
      if (ctrlWr) begin
        progRst_q  <= wbs_dat_i[0];
        progDone_q <= wbs_dat_i[1];
        irqEn_q    <= wbs_dat_i[2];
      end
      if (flush) begin
        wrPtr_q     <= '0;
        rdPtr_q     <= '0;
        fifoCount_q <= 5'd0;
        err_q       <= 1'b0;
      end else begin
        if (push) wrPtr_q <= wrPtr_q + AW'(1);
        if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
        fifoCount_q <= fifoCount_q + {4'd0, push} - {4'd0, pop};
        if (dataWr && dropWord) err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) fifoMem_q[wrPtr_q] <= wbs_dat_i;
  end

`ifdef PROG_READBACK_EN
  logic [31:0] rdata_q;
  logic [4:0]  rbCnt_q;
  logic        unusedBits;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || flush) begin
      rdata_q <= 32'd0;
      rbCnt_q <= 5'd0;
    end else if (prog_we_o) begin
      rdata_q <= {rdata_q[30:0], prog_dout};
      rbCnt_q <= rbCnt_q + 5'd1;
    end
  end

  assign rdataVal   = rdata_q;
  assign rbCnt      = rbCnt_q;
  assign unusedBits = ^wbs_sel_i[3:1];
`else
  logic unusedBits;

  assign rdataVal   = 32'd0;
  assign rbCnt      = 5'd0;
  assign unusedBits = ^{wbs_sel_i[3:1], prog_dout, prog_we_o};
`endif

  always_comb begin
    rdData = 32'd0;
    case (offset)
      8'h00:   rdData = {29'd0, irqEn_q, progDone_q, progRst_q};
      8'h04:   rdData = {19'd0, rbCnt, fifoCount_q[3:0], err_q, empty, full, busy};
      8'h0C:   rdData = wordCount_q;
      8'h10:   rdData = rdataVal;
      default: rdData = 32'd0;
    endcase
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = ack_q ? rdData : 32'd0;
  assign prog_rst  = progRst_q;
  assign prog_done = progDone_q;
  assign prog_we   = (state_q == SHIFT);
  assign prog_din  = (state_q == SHIFT) & shiftReg_q[31];
  assign irq       = irq_q;

endmodule

// File: tb/tb_wb_prog_ctrl.sv
// Scoreboard bench for wb_prog_ctrl: expected serial bits and register reads are queued at issue time
// and a negedge monitor compares them as the DUT presents prog_we / wbs_ack_o.
`timescale 1ns/1ps
module tb_wb_prog_ctrl;

  localparam logic [31:0] Base = 32'h3000_0000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic stb = 1'b0, cyc = 1'b0, weIn = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] datIn = 32'd0, adrIn = 32'd0;
  logic        ack;
  logic [31:0] datOut;
  logic progRst, progDone, progWe, progDin, irq;
  logic progDout = 1'b0, progWeOut = 1'b0;

  wb_prog_ctrl #(.FIFO_DEPTH(4), .BASE_ADDR(Base)) dut (
    .wb_clk_i (clock),
    .wb_rst_i (reset),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (weIn),
    .wbs_sel_i(sel),
    .wbs_dat_i(datIn),
    .wbs_adr_i(adrIn),
    .wbs_ack_o(ack),
    .wbs_dat_o(datOut),
    .prog_rst (progRst),
    .prog_done(progDone),
    .prog_we  (progWe),
    .prog_din (progDin),
    .prog_dout(progDout),
    .prog_we_o(progWeOut),
    .irq      (irq)
  );

  always #5 clock = ~clock;

  int vecCount = 0, missCount = 0;
  int cycleCnt = 0;
  bit          expBits[$];
  logic [31:0] expReads[$];
  string       expReadNames[$];
  string       rdName;
  int  weCycles = 0, weRises = 0, riseCycle = 0, bitsSinceRise = 0;
  logic prevWe = 1'b0, prevAck = 1'b0;
  int  reqCycle = 0, lastAckCycle = 0;
  logic lastGotAck = 1'b0;

  // Reference model of the register file, kept at the level of software-visible effects
  logic mRst = 1'b1, mDone = 1'b0, mIrqEn = 1'b0, mErr = 1'b0;
  logic [31:0] mWcount = 32'd0, mRdata = 32'd0;
  logic [4:0]  mRbCnt = 5'd0;

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  function automatic logic [31:0] expCtrl();
    return {29'd0, mIrqEn, mDone, mRst};
  endfunction

  function automatic logic [31:0] expStatus();
    logic [4:0] rb;
`ifdef PROG_READBACK_EN
    rb = mRbCnt;
`else
    rb = 5'd0;
`endif
    return {19'd0, rb, 4'd0, mErr, 1'b1, 1'b0, 1'b0};
  endfunction

  always @(negedge clock) begin
    if (ack) begin
      checkOutput("ack_single_pulse", {31'd0, prevAck}, 32'd0);
      if (!weIn) begin
        if (expReads.size() == 0) checkOutput("read_ack_unexpected", 32'd1, 32'd0);
        else begin
          rdName = expReadNames.pop_front();
          checkOutput(rdName, datOut, expReads.pop_front());
        end
      end
    end else begin
      checkOutput("dat_o_zero_idle", datOut, 32'd0);
    end
    if (progWe) begin
      if (expBits.size() == 0) checkOutput("prog_we_unexpected", 32'd1, 32'd0);
      else checkOutput("prog_din", {31'd0, progDin}, {31'd0, expBits.pop_front()});
      weCycles++;
      if (!prevWe) begin
        weRises++;
        riseCycle = cycleCnt;
        bitsSinceRise = 0;
      end
      bitsSinceRise++;
    end
    prevWe  = progWe;
    prevAck = ack;
  end

  task automatic applyStimulus(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                               input logic [3:0] be, input logic expectAck);
    int waitCycles;
    logic gotAck;
    @(posedge clock); #1;
    adrIn = adr; weIn = we; datIn = dat; sel = be; stb = 1'b1; cyc = 1'b1;
    reqCycle = cycleCnt;
    gotAck = 1'b0;
    waitCycles = 0;
    while (!gotAck && waitCycles < (expectAck ? 300 : 6)) begin
      @(negedge clock);
      if (ack) gotAck = 1'b1;
      waitCycles++;
    end
    lastAckCycle = cycleCnt;
    lastGotAck = gotAck;
    @(posedge clock); #1;
    stb = 1'b0; cyc = 1'b0; weIn = 1'b0;
    checkOutput(expectAck ? "ack_seen" : "nohit_no_ack", {31'd0, gotAck}, {31'd0, expectAck});
  endtask

  task automatic readReg(input string name, input logic [7:0] off, input logic [31:0] expected);
    expReads.push_back(expected);
    expReadNames.push_back(name);
    applyStimulus(Base | {24'd0, off}, 1'b0, 32'd0, 4'hF, 1'b1);
    if (!lastGotAck) begin
      void'(expReads.pop_back());
      void'(expReadNames.pop_back());
    end
  endtask

  task automatic flushModel();
    mWcount = 32'd0; mErr = 1'b0; mRdata = 32'd0; mRbCnt = 5'd0;
    expBits.delete();
  endtask

  task automatic ctrlWrite(input logic [31:0] val, input logic [3:0] be);
    applyStimulus(Base, 1'b1, val, be, 1'b1);
    if (be[0]) begin
      mRst = val[0]; mDone = val[1]; mIrqEn = val[2];
      if (val[0]) flushModel();
    end
  endtask

  task automatic dataWrite(input logic [31:0] word, input logic [3:0] be);
    if (mRst || mDone) mErr = 1'b1;
    else begin
      for (int i = 31; i >= 0; i--) expBits.push_back(word[i]);
      mWcount = mWcount + 32'd1;
    end
    applyStimulus(Base | 32'h08, 1'b1, word, be, 1'b1);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expBits.size() != 0 && n < 3000) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput("drain_queue_empty", 32'(expBits.size()), 32'd0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic waitBits(input int k);
    int n = 0;
    while (!(progWe && bitsSinceRise >= k) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput("reached_mid_word", {31'd0, (progWe && bitsSinceRise >= k)}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    missCount++;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    int lat[6];
    int n;
    logic [31:0] word;
    logic [7:0]  rbPattern;
    logic [31:0] expRd;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    $display("[TB] reset state");
    checkOutput("rst_prog_rst", {31'd0, progRst}, 32'd1);
    checkOutput("rst_prog_done", {31'd0, progDone}, 32'd0);
    checkOutput("rst_prog_we", {31'd0, progWe}, 32'd0);
    checkOutput("rst_prog_din", {31'd0, progDin}, 32'd0);
    checkOutput("rst_irq", {31'd0, irq}, 32'd0);
    readReg("rst_ctrl", 8'h00, expCtrl());
    readReg("rst_status", 8'h04, expStatus());
    readReg("rst_wcount", 8'h0C, 32'd0);

    $display("[TB] single word");
    ctrlWrite(32'h0, 4'h1);
    weCycles = 0; weRises = 0;
    dataWrite(32'hA500_0001, 4'h1);
    waitDrain();
    checkOutput("first_bit_latency", 32'(riseCycle - lastAckCycle), 32'd2);
    checkOutput("we_cycles_one_word", 32'(weCycles), 32'd32);
    checkOutput("we_rises_one_word", 32'(weRises), 32'd1);
    readReg("wcount_one", 8'h0C, mWcount);

    $display("[TB] six words with stall");
    ctrlWrite(32'h1, 4'h1);
    ctrlWrite(32'h4, 4'h1);
    weCycles = 0; weRises = 0;
    for (int w = 0; w < 6; w++) begin
      word = $urandom;
      dataWrite(word, 4'hF);
      lat[w] = lastAckCycle - reqCycle;
    end
    checkOutput("irq_low_while_busy", {31'd0, irq}, 32'd0);
    checkOutput("ack_latency_free", 32'(lat[0]), 32'd1);
    checkOutput("ack_stalled_sixth", {31'd0, (lat[5] > 1)}, 32'd1);
    waitDrain();
    checkOutput("we_cycles_six", 32'(weCycles), 32'd192);
    checkOutput("we_rises_six", 32'(weRises), 32'd1);
    checkOutput("irq_after_drain", {31'd0, irq}, 32'd1);
    readReg("wcount_six", 8'h0C, mWcount);
    readReg("status_six", 8'h04, expStatus());
    readReg("ctrl_irq_en", 8'h00, expCtrl());

    $display("[TB] mid-word programming reset");
    ctrlWrite(32'h0, 4'h1);
    bitsSinceRise = 0;
    word = $urandom;
    dataWrite(word, 4'hF);
    waitBits(10);
    ctrlWrite(32'h1, 4'h1);
    checkOutput("we_after_flush", {31'd0, progWe}, 32'd0);
    checkOutput("din_after_flush", {31'd0, progDin}, 32'd0);
    readReg("status_flush", 8'h04, expStatus());
    readReg("wcount_flush", 8'h0C, mWcount);

    $display("[TB] writes while held in reset or done");
    dataWrite(32'h1234_5678, 4'hF);
    repeat (40) @(posedge clock);
    #1;
    checkOutput("we_idle_in_rst", {31'd0, progWe}, 32'd0);
    readReg("status_err_rst", 8'h04, expStatus());
    ctrlWrite(32'h2, 4'h1);
    word = $urandom;
    dataWrite(word, 4'hF);
    repeat (40) @(posedge clock);
    #1;
    checkOutput("prog_done_pin", {31'd0, progDone}, {31'd0, mDone});
    readReg("ctrl_done", 8'h00, expCtrl());
    readReg("status_err_done", 8'h04, expStatus());
    ctrlWrite(32'h1, 4'h1);
    readReg("status_err_cleared", 8'h04, expStatus());
    ctrlWrite(32'h0, 4'h1);
    ctrlWrite(32'h7, 4'hE);
    readReg("ctrl_sel_ignored", 8'h00, expCtrl());
    checkOutput("prog_rst_pin", {31'd0, progRst}, {31'd0, mRst});

    $display("[TB] decode");
    readReg("unmapped_14", 8'h14, 32'd0);
    readReg("data_reads_zero", 8'h08, 32'd0);
    applyStimulus(Base | 32'h20, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b1);
    applyStimulus(32'h3000_0104, 1'b0, 32'd0, 4'hF, 1'b0);
    applyStimulus(32'h2000_0000, 1'b1, 32'h0000_0001, 4'hF, 1'b0);
    readReg("ctrl_after_nohit", 8'h00, expCtrl());

    $display("[TB] readback");
    rbPattern = 8'b1100_1010;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      progWeOut = 1'b1;
      progDout  = rbPattern[7-i];
      mRdata = {mRdata[30:0], rbPattern[7-i]};
      mRbCnt = mRbCnt + 5'd1;
    end
    @(posedge clock); #1;
    progWeOut = 1'b0;
    progDout  = 1'b0;
`ifdef PROG_READBACK_EN
    expRd = mRdata;
`else
    expRd = 32'd0;
`endif
    readReg("rdata", 8'h10, expRd);
    readReg("status_rb", 8'h04, expStatus());

    $display("[TB] randomized traffic");
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(1, 6);
      for (int w = 0; w < n; w++) begin
        word = $urandom;
        dataWrite(word, 4'($urandom));
        repeat ($urandom_range(0, 3)) @(posedge clock);
      end
      if ($urandom_range(0, 1) == 1) readReg("unmapped_rand", 8'(8'h14 + 4 * $urandom_range(0, 10)), 32'd0);
      waitDrain();
      readReg("wcount_rand", 8'h0C, mWcount);
      readReg("status_rand", 8'h04, expStatus());
    end

    $display("[TB] bus reset mid-shift");
    bitsSinceRise = 0;
    word = $urandom;
    dataWrite(word, 4'hF);
    waitBits(5);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    checkOutput("we_after_bus_reset", {31'd0, progWe}, 32'd0);
    mRst = 1'b1; mDone = 1'b0; mIrqEn = 1'b0;
    flushModel();
    readReg("ctrl_bus_reset", 8'h00, expCtrl());
    readReg("wcount_bus_reset", 8'h0C, mWcount);
    readReg("status_bus_reset", 8'h04, expStatus());
    repeat (5) @(posedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
